// File: rtl/tqvp_affinex_stream_if.sv
// TinyQV peripheral bus bundle for the streaming affine engine.
// The CPU side drives address/data/strobes; the peripheral answers with
// combinational read data, a constant ready and its interrupt line.
interface tqvp_affinex_stream_if;
  logic [5:0]  address;
  logic [31:0] data_in;
  logic [1:0]  data_write_n;
  logic [1:0]  data_read_n;
  logic [31:0] data_out;
  logic        data_ready;
  logic        user_interrupt;

  modport master (
    output address, data_in, data_write_n, data_read_n,
    input  data_out, data_ready, user_interrupt
  );

  modport slave (
    input  address, data_in, data_write_n, data_read_n,
    output data_out, data_ready, user_interrupt
  );
endinterface

// File: rtl/tqvp_affinex_stream.sv
// Streaming affine transform peripheral:
//   x' = a*x + b*y + tx,  y' = d*x + e*y + ty  (signed, FRAC fractional bits)
// Points enter through an input FIFO, run through a sequencer that time-shares
// one WIDTHxWIDTH multiplier over four states, and land in an output FIFO.
module tqvp_affinex_stream #(
  parameter int WIDTH = 16,
  parameter int FRAC  = 8,
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  tqvp_affinex_stream_if.slave bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int MW = 2 * WIDTH;
  localparam int SW = MW + 1;
  localparam int RW = SW + 1;

  localparam logic [5:0] ADDR_CTRL   = 6'h00;
  localparam logic [5:0] ADDR_STATUS = 6'h04;
  localparam logic [5:0] ADDR_A      = 6'h08;
  localparam logic [5:0] ADDR_B      = 6'h0C;
  localparam logic [5:0] ADDR_D      = 6'h10;
  localparam logic [5:0] ADDR_E      = 6'h14;
  localparam logic [5:0] ADDR_TX     = 6'h18;
  localparam logic [5:0] ADDR_TY     = 6'h1C;
  localparam logic [5:0] ADDR_PUSH   = 6'h20;
  localparam logic [5:0] ADDR_POP    = 6'h24;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAX  = 3'd1;
  localparam logic [2:0] S_MBY  = 3'd2;
  localparam logic [2:0] S_MDX  = 3'd3;
  localparam logic [2:0] S_MEY  = 3'd4;
  localparam logic [2:0] S_WR   = 3'd5;

  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = {{(RW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic enable, irq_en, sat;
  logic signed [WIDTH-1:0] a_q, b_q, d_q, e_q, tx_q, ty_q;
  logic overflow, underflow, irq_q;

  logic signed [WIDTH-1:0] in_x [DEPTH];
  logic signed [WIDTH-1:0] in_y [DEPTH];
  logic signed [WIDTH-1:0] out_x [DEPTH];
  logic signed [WIDTH-1:0] out_y [DEPTH];
  logic [PW-1:0] in_wptr, in_rptr, out_wptr, out_rptr;
  logic [CW-1:0] in_count, out_count;

  logic [2:0] state;
  logic signed [WIDTH-1:0] x_q, y_q, mul_a, mul_b;
  logic signed [MW-1:0] mul_p, prod;
  logic signed [SW-1:0] sum_x, sum_y, sum_y_full, sx_sh, sy_sh;
  logic signed [RW-1:0] rx, ry;
  logic [WIDTH-1:0] res_x, res_y;

  logic wr_en, rd_en, flush, push_req, pop_req;
  logic in_full, in_empty, out_full, out_empty, busy;
  logic push_ok, eng_pop, out_pop, eng_wr;
  logic [31:0] data_out_c;
  logic unused_bits;

  assign wr_en     = bus.data_write_n != 2'b11;
  assign rd_en     = bus.data_read_n != 2'b11;
  assign flush     = wr_en && (bus.address == ADDR_CTRL) && bus.data_in[3];
  assign push_req  = wr_en && (bus.address == ADDR_PUSH);
  assign pop_req   = rd_en && (bus.address == ADDR_POP);

  assign in_full   = in_count == CW'(DEPTH);
  assign in_empty  = in_count == '0;
  assign out_full  = out_count == CW'(DEPTH);
  assign out_empty = out_count == '0;
  assign busy      = state != S_IDLE;

  assign push_ok   = push_req && !in_full && !flush;
  assign eng_pop   = (state == S_IDLE) && enable && !in_empty && !flush;
  assign out_pop   = pop_req && !out_empty && !flush;
  assign eng_wr    = (state == S_WR) && (!out_full || out_pop) && !flush;

  assign uo_out         = 8'h00;
  assign bus.data_ready = 1'b1;
  assign bus.user_interrupt = irq_q;
  assign bus.data_out   = data_out_c;
  assign unused_bits    = ^{ui_in, bus.data_in};

  // Either clamp to the signed WIDTH range or keep the low bits and wrap.
  function automatic logic [WIDTH-1:0] fit(input logic signed [RW-1:0] v, input logic clamp);
    logic [WIDTH-1:0] r;
    r = v[WIDTH-1:0];
    if (clamp) begin
      if (v > SAT_MAX)      r = {1'b0, {(WIDTH-1){1'b1}}};
      else if (v < SAT_MIN) r = {1'b1, {(WIDTH-1){1'b0}}};
    end
    return r;
  endfunction

  // Control and coefficient registers; flush is a strobe and never stored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable <= 1'b0;
      irq_en <= 1'b0;
      sat    <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      d_q    <= '0;
      e_q    <= '0;
      tx_q   <= '0;
      ty_q   <= '0;
    end else if (wr_en) begin
      case (bus.address)
        ADDR_CTRL: begin
          enable <= bus.data_in[0];
          irq_en <= bus.data_in[1];
          sat    <= bus.data_in[2];
        end
        ADDR_A:  a_q  <= bus.data_in[WIDTH-1:0];
        ADDR_B:  b_q  <= bus.data_in[WIDTH-1:0];
        ADDR_D:  d_q  <= bus.data_in[WIDTH-1:0];
        ADDR_E:  e_q  <= bus.data_in[WIDTH-1:0];
        ADDR_TX: tx_q <= bus.data_in[WIDTH-1:0];
        ADDR_TY: ty_q <= bus.data_in[WIDTH-1:0];
        default: ;
      endcase
    end
  end

  // Sticky error flags: set on dropped PUSH or empty POP, cleared by flush.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (flush) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_req && in_full)  overflow  <= 1'b1;
      if (pop_req && out_empty) underflow <= 1'b1;
    end
  end

  // Input FIFO pointers and occupancy; bus push and engine pop may coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_wptr  <= '0;
      in_rptr  <= '0;
      in_count <= '0;
    end else if (flush) begin
      in_wptr  <= '0;
      in_rptr  <= '0;
      in_count <= '0;
    end else begin
      if (push_ok) in_wptr <= in_wptr + PW'(1);
      if (eng_pop) in_rptr <= in_rptr + PW'(1);
      if (push_ok && !eng_pop)      in_count <= in_count + CW'(1);
      else if (!push_ok && eng_pop) in_count <= in_count - CW'(1);
    end
  end

  // Input FIFO storage; contents only matter where the count says they are valid.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      in_x[in_wptr] <= bus.data_in[WIDTH-1:0];
      in_y[in_wptr] <= bus.data_in[16+WIDTH-1:16];
    end
  end

  // Sequencer: one multiply per state, then hold in WR until the output FIFO has room.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      x_q   <= '0;
      y_q   <= '0;
    end else if (flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (eng_pop) begin
          state <= S_MAX;
          x_q   <= in_x[in_rptr];
          y_q   <= in_y[in_rptr];
        end
        S_MAX:   state <= S_MBY;
        S_MBY:   state <= S_MDX;
        S_MDX:   state <= S_MEY;
        S_MEY:   state <= S_WR;
        S_WR:    if (eng_wr) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Operand select for the shared multiplier; coefficients are read live.
  always_comb begin
    mul_a = a_q;
    mul_b = x_q;
    case (state)
      S_MBY: begin mul_a = b_q; mul_b = y_q; end
      S_MDX: begin mul_a = d_q; mul_b = x_q; end
      S_MEY: begin mul_a = e_q; mul_b = y_q; end
      default: ;
    endcase
  end

  assign mul_p = MW'(mul_a) * MW'(mul_b);

  // Product register and full-width accumulators; the last product is folded in combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prod  <= '0;
      sum_x <= '0;
      sum_y <= '0;
    end else begin
      case (state)
        S_MAX: prod <= mul_p;
        S_MBY: begin
          sum_x <= $signed({prod[MW-1], prod});
          prod  <= mul_p;
        end
        S_MDX: begin
          sum_x <= sum_x + $signed({prod[MW-1], prod});
          prod  <= mul_p;
        end
        S_MEY: begin
          sum_y <= $signed({prod[MW-1], prod});
          prod  <= mul_p;
        end
        default: ;
      endcase
    end
  end

  // Shift back to coordinate scale (floor), add translation, then clamp or wrap.
  always_comb begin
    sum_y_full = sum_y + $signed({prod[MW-1], prod});
    sx_sh = sum_x >>> FRAC;
    sy_sh = sum_y_full >>> FRAC;
    rx = $signed({sx_sh[SW-1], sx_sh}) + $signed({{(RW-WIDTH){tx_q[WIDTH-1]}}, tx_q});
    ry = $signed({sy_sh[SW-1], sy_sh}) + $signed({{(RW-WIDTH){ty_q[WIDTH-1]}}, ty_q});
    res_x = fit(rx, sat);
    res_y = fit(ry, sat);
  end

  // Output FIFO pointers and occupancy; a full FIFO still takes WR on a same-cycle POP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
    end else if (flush) begin
      out_wptr  <= '0;
      out_rptr  <= '0;
      out_count <= '0;
    end else begin
      if (eng_wr)  out_wptr <= out_wptr + PW'(1);
      if (out_pop) out_rptr <= out_rptr + PW'(1);
      if (eng_wr && !out_pop)      out_count <= out_count + CW'(1);
      else if (!eng_wr && out_pop) out_count <= out_count - CW'(1);
    end
  end

  // Output FIFO storage.
  always_ff @(posedge clk) begin
    if (eng_wr) begin
      out_x[out_wptr] <= res_x;
      out_y[out_wptr] <= res_y;
    end
  end

  // Level interrupt, registered one cycle behind the data-available condition.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= irq_en && !out_empty;
  end

  // Read mux; an empty output FIFO reports out_empty even straight out of reset.
  always_comb begin
    data_out_c = 32'h0;
    case (bus.address)
      ADDR_CTRL:   data_out_c = {29'h0, sat, irq_en, enable};
      ADDR_STATUS: data_out_c = {19'h0, underflow, overflow, out_empty, in_full, busy,
                                 4'(out_count), 4'(in_count)};
      ADDR_A:      data_out_c = 32'(a_q);
      ADDR_B:      data_out_c = 32'(b_q);
      ADDR_D:      data_out_c = 32'(d_q);
      ADDR_E:      data_out_c = 32'(e_q);
      ADDR_TX:     data_out_c = 32'(tx_q);
      ADDR_TY:     data_out_c = 32'(ty_q);
      ADDR_POP:    if (!out_empty)
                     data_out_c = {16'(out_y[out_rptr]), 16'(out_x[out_rptr])};
      default:     data_out_c = 32'h0;
    endcase
  end

endmodule

// File: tb/tb_tqvp_affinex_stream.sv
// Testbench for tqvp_affinex_stream (WIDTH=16, FRAC=8, DEPTH=4).
// Expected POP words come from a vector table or from a small reference
// model and are queued when a point is pushed, then checked when popped.
module tb_tqvp_affinex_stream;

  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h04;
  localparam logic [5:0] A_A      = 6'h08;
  localparam logic [5:0] A_B      = 6'h0C;
  localparam logic [5:0] A_D      = 6'h10;
  localparam logic [5:0] A_E      = 6'h14;
  localparam logic [5:0] A_TX     = 6'h18;
  localparam logic [5:0] A_TY     = 6'h1C;
  localparam logic [5:0] A_PUSH   = 6'h20;
  localparam logic [5:0] A_POP    = 6'h24;

  typedef struct {
    logic [15:0] a, b, d, e, tx, ty;
    logic        sat;
    logic [15:0] x, y;
    logic [31:0] expPop;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] ui_in;
  logic [7:0] uo_out;

  tqvp_affinex_stream_if bus ();

  tqvp_affinex_stream #(.WIDTH(16), .FRAC(8), .DEPTH(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb [$];
  vec_t vecs [9];

  // Hard stop if something hangs outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic flagFail(input string name);
    checks++;
    fails++;
    $display("[TB] FAIL %s: condition not reached within cycle budget", name);
  endtask

  task automatic busWrite(input logic [5:0] addr, input logic [31:0] data);
    @(negedge clk);
    bus.address      = addr;
    bus.data_in      = data;
    bus.data_write_n = 2'b00;
    @(posedge clk);
    #1;
    bus.data_write_n = 2'b11;
  endtask

  task automatic busRead(input logic [5:0] addr, output logic [31:0] data);
    @(negedge clk);
    bus.address = addr;
    #1;
    data = bus.data_out;
  endtask

  task automatic busPeek(input logic [5:0] addr, output logic [31:0] data);
    bus.address = addr;
    #1;
    data = bus.data_out;
  endtask

  task automatic popRaw(output logic [31:0] data);
    @(negedge clk);
    bus.address     = A_POP;
    bus.data_read_n = 2'b00;
    #1;
    data = bus.data_out;
    @(posedge clk);
    #1;
    bus.data_read_n = 2'b11;
  endtask

  task automatic popCheck(input string name);
    logic [31:0] d;
    popRaw(d);
    if (sb.size() == 0) flagFail({name, " (scoreboard empty)"});
    else checkOutput(name, d, sb.pop_front());
  endtask

  task automatic waitStatus(input logic [31:0] mask, input logic [31:0] want, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      #1;
      bus.address = A_STATUS;
      #1;
      if ((bus.data_out & mask) == want) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flagFail(name);
  endtask

  function automatic logic [15:0] fit16(input longint v, input bit sat);
    longint w;
    w = v;
    if (sat && w > 32767)  w = 32767;
    if (sat && w < -32768) w = -32768;
    return w[15:0];
  endfunction

  // Reference: floor((a*x + b*y) / 256) + t, then clamp or wrap to 16 bits.
  function automatic logic [31:0] modelPoint(input logic signed [15:0] a, b, d, e, tx, ty,
                                             input logic signed [15:0] x, y, input bit sat);
    longint sx, sy;
    sx = (longint'(a) * longint'(x) + longint'(b) * longint'(y)) >>> 8;
    sy = (longint'(d) * longint'(x) + longint'(e) * longint'(y)) >>> 8;
    return {fit16(sy + longint'(ty), sat), fit16(sx + longint'(tx), sat)};
  endfunction

  task automatic setCoefs(input logic [15:0] a, b, d, e, tx, ty);
    busWrite(A_A,  {16'h0, a});
    busWrite(A_B,  {16'h0, b});
    busWrite(A_D,  {16'h0, d});
    busWrite(A_E,  {16'h0, e});
    busWrite(A_TX, {16'h0, tx});
    busWrite(A_TY, {16'h0, ty});
  endtask

  task automatic applyStimulus(input vec_t v);
    busWrite(A_CTRL, {29'h0, v.sat, 1'b0, 1'b1});
    setCoefs(v.a, v.b, v.d, v.e, v.tx, v.ty);
    busWrite(A_PUSH, {v.y, v.x});
    sb.push_back(v.expPop);
  endtask

  initial begin
    logic [31:0] d;
    logic [15:0] px, py;

    vecs[0] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0005, 16'hFFFD, 1'b0, 16'h000A, 16'h0014, 32'h0011_000F};
    vecs[1] = '{16'h0000, 16'hFF00, 16'h0100, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h0003, 16'h0004, 32'h0003_FFFC};
    vecs[2] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, 32'h0000_7FFF};
    vecs[3] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 32'h0000_FF00};
    vecs[4] = '{16'h0080, 16'h0000, 16'h0000, 16'h0080, 16'h0000, 16'h0000, 1'b0, 16'hFFFD, 16'h0003, 32'h0001_FFFE};
    vecs[5] = '{16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 1'b1, 16'h8000, 16'h7FFF, 32'h7FFF_8000};
    vecs[6] = '{16'h0200, 16'h0100, 16'hFF00, 16'h0300, 16'h0010, 16'hFFF0, 1'b0, 16'h0007, 16'hFFFB, 32'hFFDA_0019};
    vecs[7] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0001, 16'h0000, 1'b0, 16'h7FFF, 16'h0000, 32'h0000_8000};
    vecs[8] = '{16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0001, 16'h0000, 1'b1, 16'h7FFF, 16'h0000, 32'h0000_7FFF};

    rst              = 1'b1;
    ui_in            = 8'h00;
    bus.address      = 6'h00;
    bus.data_in      = 32'h0;
    bus.data_write_n = 2'b11;
    bus.data_read_n  = 2'b11;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    busRead(A_STATUS, d); checkOutput("reset STATUS", d, 32'h0000_0400);
    busRead(A_CTRL, d);   checkOutput("reset CTRL", d, 32'h0);
    busRead(A_A, d);      checkOutput("reset A", d, 32'h0);
    busRead(A_POP, d);    checkOutput("reset POP", d, 32'h0);
    busRead(6'h28, d);    checkOutput("unmapped read", d, 32'h0);
    checkOutput("reset irq", {31'h0, bus.user_interrupt}, 32'h0);
    checkOutput("uo_out", {24'h0, uo_out}, 32'h0);
    checkOutput("data_ready", {31'h0, bus.data_ready}, 32'h1);

    // Register access: sign extension, RO write ignored, flush bit reads 0
    busWrite(A_B, 32'h0000_FF00);
    busRead(A_B, d);      checkOutput("B sign-extend", d, 32'hFFFF_FF00);
    busWrite(A_STATUS, 32'hFFFF_FFFF);
    busRead(A_STATUS, d); checkOutput("STATUS write ignored", d, 32'h0000_0400);
    busWrite(A_CTRL, 32'h0000_000F);
    busRead(A_CTRL, d);   checkOutput("CTRL flush reads 0", d, 32'h0000_0007);
    busWrite(A_CTRL, 32'h0);

    // Identity+translate with exact latency
    setCoefs(16'h0100, 16'h0000, 16'h0000, 16'h0100, 16'h0005, 16'hFFFD);
    busWrite(A_CTRL, 32'h1);
    busWrite(A_PUSH, {16'd20, 16'd10});
    sb.push_back(32'h0011_000F);
    repeat (5) @(posedge clk);
    #1;
    busPeek(A_STATUS, d); checkOutput("latency WR not yet out", d, 32'h0000_0500);
    @(posedge clk);
    #1;
    busPeek(A_STATUS, d); checkOutput("latency result visible", d, 32'h0000_0010);
    popCheck("identity POP");
    checkOutput("irq disabled", {31'h0, bus.user_interrupt}, 32'h0);

    // Table vectors
    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i]);
      waitStatus(32'h0000_00F0, 32'h0000_0010, 30, $sformatf("vec%0d result ready", i));
      popCheck($sformatf("vec%0d POP", i));
    end

    // Underflow on empty POP
    popRaw(d);            checkOutput("empty POP data", d, 32'h0);
    busRead(A_STATUS, d); checkOutput("underflow STATUS", d, 32'h0000_1400);

    // Input overflow with engine disabled, then drain in push order
    busWrite(A_CTRL, 32'h8);
    busRead(A_STATUS, d); checkOutput("flush clears sticky", d, 32'h0000_0400);
    setCoefs(16'h0180, 16'hFFC0, 16'h0040, 16'h0100, 16'h0007, 16'hFFF7);
    busWrite(A_CTRL, 32'h4);
    for (int i = 0; i < 5; i++) begin
      px = 16'($urandom());
      py = 16'($urandom());
      busWrite(A_PUSH, {py, px});
      if (i < 4) sb.push_back(modelPoint(16'h0180, 16'hFFC0, 16'h0040, 16'h0100, 16'h0007, 16'hFFF7, px, py, 1'b1));
    end
    busRead(A_STATUS, d); checkOutput("overflow STATUS", d, 32'h0000_0E04);
    busWrite(A_CTRL, 32'h5);
    waitStatus(32'h0000_00F0, 32'h0000_0040, 80, "overflow drain");
    for (int i = 0; i < 4; i++) popCheck($sformatf("overflow POP%0d", i));
    busRead(A_STATUS, d); checkOutput("overflow sticky kept", d, 32'h0000_0C00);

    // Output backpressure: WR stalls until a POP frees a slot
    busWrite(A_CTRL, 32'h8);
    busWrite(A_CTRL, 32'h1);
    for (int i = 0; i < 6; i++) begin
      px = 16'($urandom());
      py = 16'($urandom());
      busWrite(A_PUSH, {py, px});
      sb.push_back(modelPoint(16'h0180, 16'hFFC0, 16'h0040, 16'h0100, 16'h0007, 16'hFFF7, px, py, 1'b0));
      repeat (4) @(posedge clk);
    end
    waitStatus(32'hFFFF_FFFF, 32'h0000_0141, 100, "backpressure stall");
    repeat (8) @(posedge clk);
    #1;
    busPeek(A_STATUS, d); checkOutput("stall holds", d, 32'h0000_0141);
    popCheck("stall POP0");
    busPeek(A_STATUS, d); checkOutput("WR taken on POP", d, 32'h0000_0041);
    @(posedge clk);
    #1;
    busPeek(A_STATUS, d); checkOutput("next point started", d, 32'h0000_0140);
    for (int i = 1; i < 5; i++) popCheck($sformatf("stall POP%0d", i));
    waitStatus(32'h0000_01FF, 32'h0000_0010, 30, "last stalled point");
    popCheck("stall POP5");

    // Interrupt and flush
    busWrite(A_CTRL, 32'h8);
    busWrite(A_CTRL, 32'h3);
    busWrite(A_PUSH, {16'h0100, 16'h0200});
    sb.push_back(modelPoint(16'h0180, 16'hFFC0, 16'h0040, 16'h0100, 16'h0007, 16'hFFF7, 16'h0200, 16'h0100, 1'b0));
    waitStatus(32'h0000_00F0, 32'h0000_0010, 30, "irq result ready");
    checkOutput("irq registered delay", {31'h0, bus.user_interrupt}, 32'h0);
    @(posedge clk);
    #1;
    checkOutput("irq asserted", {31'h0, bus.user_interrupt}, 32'h1);
    busWrite(A_CTRL, 32'h8);
    void'(sb.pop_back());
    busPeek(A_STATUS, d); checkOutput("flush STATUS", d, 32'h0000_0400);
    checkOutput("irq still high at flush edge", {31'h0, bus.user_interrupt}, 32'h1);
    @(posedge clk);
    #1;
    checkOutput("irq dropped", {31'h0, bus.user_interrupt}, 32'h0);

    // Flush discards an in-flight point
    busWrite(A_CTRL, 32'h1);
    busWrite(A_PUSH, {16'h0011, 16'h0022});
    repeat (2) @(posedge clk);
    busWrite(A_CTRL, 32'h9);
    repeat (12) @(posedge clk);
    #1;
    busPeek(A_STATUS, d); checkOutput("in-flight discarded", d, 32'h0000_0400);

    // Reset while the engine is in MBY
    busWrite(A_PUSH, {16'h0033, 16'h0044});
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    busPeek(A_STATUS, d); checkOutput("rst STATUS", d, 32'h0000_0400);
    busPeek(A_CTRL, d);   checkOutput("rst CTRL", d, 32'h0);
    busPeek(A_A, d);      checkOutput("rst A", d, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(posedge clk);
    #1;
    busPeek(A_STATUS, d); checkOutput("no output after rst", d, 32'h0000_0400);
    busPeek(A_POP, d);    checkOutput("POP after rst", d, 32'h0);
    checkOutput("scoreboard drained", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
